muldiv_iter: RTL and testbench

- Parametrised iterative multiply/divide unit for the EX stage. It replaces the fixed 32-bit divider and the separate two-cycle multiplier with one shared shift/add-subtract datapath.
- Supports signed and unsigned multiply and divide at any even WIDTH, with a one-cycle completion handshake, pipeline flush abort and divide-by-zero detection.
- Results go to the HI/LO write path, exactly as the EX-to-MEM hilo bus carries them today.

---
 rtl/muldiv_iter.sv | 207 ++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative multiply/divide unit for the EX stage.
//
// One shared radix-2 datapath handles both operation classes:
//   - multiply: LSB-first shift-add on a 2*WIDTH accumulator {acc_hi, acc_lo}
//   - divide:   MSB-first restoring division; acc_hi is the partial remainder and
//               acc_lo shifts the dividend out while the quotient bits shift in
// Signed operations run on operand magnitudes. The result signs are applied
// in the FIN cycle, before hi_o/lo_o are registered.
//
// Ports:
//   clk      rising-edge clock
//   resetn   asynchronous active-low reset
//   start_i  request an operation (sampled only while idle)
//   op_i     00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   src1_i   multiplicand / dividend
//   src2_i   multiplier / divisor
//   flush_i  abort the operation in progress; no done_o follows
//   busy_o   unit occupied (CALC or FIN)
//   done_o   one-cycle pulse: hi_o, lo_o and dbz_o are valid
//   hi_o     product upper half / remainder
//   lo_o     product lower half / quotient
//   dbz_o    divide-by-zero flag, meaningful with done_o
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             dbz_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               is_dbz;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;

    // Request decode. A negative signed operand is replaced by its magnitude.
    // The most negative value negates to itself, and that bit pattern is
    // already the correct unsigned magnitude 2^(WIDTH-1).
    logic               sign1;
    logic               sign2;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic               dbz_req;

    always_comb begin
        sign1   = op_i[0] & src1_i[WIDTH-1];
        sign2   = op_i[0] & src2_i[WIDTH-1];
        mag1    = sign1 ? -src1_i : src1_i;
        mag2    = sign2 ? -src2_i : src2_i;
        dbz_req = op_i[1] & (src2_i == '0);
    end

    // One radix-2 step.
    // Multiply: the add carries into bit WIDTH, and that carry becomes the new
    //   MSB of acc_hi after the right shift.
    // Divide: the shifted remainder needs WIDTH+1 bits. After a successful
    //   subtract the remainder is below the divisor, so WIDTH bits of the
    //   difference are enough.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH + 1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        if (is_div) begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign correction for the FIN cycle. A product is negated across the full
    // 2*WIDTH bits. Quotient and remainder are negated separately, modulo
    // 2^WIDTH. A divide-by-zero already holds its final raw values in the
    // accumulators.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_q ? -prod : prod;
        if (is_dbz) begin
            fin_hi = acc_hi;
            fin_lo = acc_lo;
        end else if (is_div) begin
            fin_hi = neg_r ? -acc_hi : acc_hi;
            fin_lo = neg_q ? -acc_lo : acc_lo;
        end else begin
            fin_hi = prod_fix[2*WIDTH-1:WIDTH];
            fin_lo = prod_fix[WIDTH-1:0];
        end
    end

    // Control FSM, with all outputs registered.
    // The result registers change only in a FIN cycle that is not flushed, so
    // an aborted operation leaves the previous results visible.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            is_dbz <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
            dbz_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && !flush_i) begin
                        is_div <= op_i[1];
                        busy_o <= 1'b1;
                        cnt    <= '0;
                        if (dbz_req) begin
                            // Divide by zero skips the iterations. The raw
                            // dividend and an all-ones quotient go straight to FIN.
                            state  <= FIN;
                            is_dbz <= 1'b1;
                            neg_q  <= 1'b0;
                            neg_r  <= 1'b0;
                            opnd   <= '0;
                            acc_hi <= src1_i;
                            acc_lo <= '1;
                        end else begin
                            state  <= CALC;
                            is_dbz <= 1'b0;
                            neg_q  <= sign1 ^ sign2;
                            neg_r  <= sign1;
                            acc_hi <= '0;
                            acc_lo <= op_i[1] ? mag1 : mag2;
                            opnd   <= op_i[1] ? mag2 : mag1;
                        end
                    end
                end

                CALC: begin
                    if (flush_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state <= FIN;
                        end
                    end
                end

                FIN: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    if (!flush_i) begin
                        hi_o   <= fin_hi;
                        lo_o   <= fin_lo;
                        dbz_o  <= is_dbz;
                        done_o <= 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: scoreboard testbench for muldiv_iter.
//
// Two instances share one clock and one reset: a 32-bit unit and an 8-bit unit.
// Each accepted operation pushes its expected result to a queue, together with
// the cycle in which done_o should appear. The expected result comes from a
// behavioural model built on native multiply, divide and modulo. A monitor
// pops an entry on every done_o pulse and compares it with the outputs.
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        resetn;

    logic        start32, flush32, busy32, done32, dbz32;
    logic [1:0]  op32;
    logic [31:0] src1_32, src2_32, hi32, lo32;

    logic        start8, flush8, busy8, done8, dbz8;
    logic [1:0]  op8;
    logic [7:0]  src1_8, src2_8, hi8, lo8;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t mon32;
    exp_t mon8;

    always #5 clk = ~clk;

    // Count rising edges so that done_o timing can be checked.
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .resetn(resetn), .start_i(start32), .op_i(op32),
        .src1_i(src1_32), .src2_i(src2_32), .flush_i(flush32),
        .busy_o(busy32), .done_o(done32), .hi_o(hi32), .lo_o(lo32), .dbz_o(dbz32)
    );

    muldiv_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .resetn(resetn), .start_i(start8), .op_i(op8),
        .src1_i(src1_8), .src2_i(src2_8), .flush_i(flush8),
        .busy_o(busy8), .done_o(done8), .hi_o(hi8), .lo_o(lo8), .dbz_o(dbz8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Reference model on signed 64-bit arithmetic. Division truncates toward
    // zero and the remainder takes the sign of the dividend.
    function automatic exp_t modelOp(input int w, input logic [1:0] opc,
                                     input logic [31:0] x, input logic [31:0] y);
        longint mask, sx, sy, r;
        exp_t   e;
        mask = (longint'(1) << w) - 1;
        sx = longint'(x) & mask;
        sy = longint'(y) & mask;
        if (opc[0]) begin
            if (sx[w-1]) sx = sx - (longint'(1) << w);
            if (sy[w-1]) sy = sy - (longint'(1) << w);
        end
        e.dbz = 1'b0;
        e.due = 0;
        if (!opc[1]) begin
            r    = sx * sy;
            e.hi = 32'((r >>> w) & mask);
            e.lo = 32'(r & mask);
        end else if (sy == 0) begin
            e.dbz = 1'b1;
            e.lo  = 32'(mask);
            e.hi  = x & 32'(mask);
        end else begin
            e.lo = 32'((sx / sy) & mask);
            e.hi = 32'((sx % sy) & mask);
        end
        return e;
    endfunction

    // Drive one request for a single cycle and wait for its start edge. The
    // expected result is queued only when a done_o pulse should follow.
    task automatic applyStimulus(input bit use8, input logic [1:0] opc,
                                 input logic [31:0] x, input logic [31:0] y,
                                 input bit expect_done);
        exp_t e;
        int   w;
        w = use8 ? 8 : 32;
        e = modelOp(w, opc, x, y);
        @(negedge clk);
        if (use8) begin
            op8 = opc; src1_8 = x[7:0]; src2_8 = y[7:0]; start8 = 1'b1;
        end else begin
            op32 = opc; src1_32 = x; src2_32 = y; start32 = 1'b1;
        end
        @(posedge clk);
        #1;
        e.due = cyc + (e.dbz ? 1 : w + 1);
        if (expect_done) begin
            if (use8) q8.push_back(e);
            else      q32.push_back(e);
        end
        start8  = 1'b0;
        start32 = 1'b0;
    endtask

    task automatic waitDone(input bit use8, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (use8 ? done8 : done32) seen = 1'b1;
        end
        if (!seen) begin
            if (use8) checkOutput("timeout_done8", 64'(seen), 64'd1);
            else      checkOutput("timeout_done32", 64'(seen), 64'd1);
        end
    endtask

    // Scoreboard monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (resetn && done32) begin
            if (q32.size() == 0) begin
                checkOutput("done32_unexpected", 64'(done32), 64'd0);
            end else begin
                mon32 = q32.pop_front();
                checkOutput("lat32", 64'(cyc), 64'(mon32.due));
                checkOutput("hi32", 64'(hi32), 64'(mon32.hi));
                checkOutput("lo32", 64'(lo32), 64'(mon32.lo));
                checkOutput("dbz32", 64'(dbz32), 64'(mon32.dbz));
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && done8) begin
            if (q8.size() == 0) begin
                checkOutput("done8_unexpected", 64'(done8), 64'd0);
            end else begin
                mon8 = q8.pop_front();
                checkOutput("lat8", 64'(cyc), 64'(mon8.due));
                checkOutput("hi8", 64'(hi8), 64'(mon8.hi));
                checkOutput("lo8", 64'(lo8), 64'(mon8.lo));
                checkOutput("dbz8", 64'(dbz8), 64'(mon8.dbz));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   c0;
        exp_t e;

        resetn = 1'b0;
        start32 = 1'b0; flush32 = 1'b0; op32 = 2'b00; src1_32 = '0; src2_32 = '0;
        start8  = 1'b0; flush8  = 1'b0; op8  = 2'b00; src1_8  = '0; src2_8  = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 64'(busy32), 64'd0);
        checkOutput("rst_done", 64'(done32), 64'd0);
        checkOutput("rst_hi", 64'(hi32), 64'd0);
        checkOutput("rst_lo", 64'(lo32), 64'd0);
        checkOutput("rst_dbz", 64'(dbz32), 64'd0);
        checkOutput("rst_busy8", 64'(busy8), 64'd0);
        resetn = 1'b1;

        // Signed multiply, signed and unsigned divide.
        applyStimulus(0, 2'b01, 32'hFFFFFFFD, 32'h00000005, 1); waitDone(0, 50);
        applyStimulus(0, 2'b11, 32'hFFFFFFF9, 32'h00000002, 1); waitDone(0, 50);
        applyStimulus(0, 2'b10, 32'hFFFFFFF9, 32'h00000002, 1); waitDone(0, 50);

        // Boundary divides: divide by zero, then MIN / -1.
        applyStimulus(0, 2'b10, 32'h00000007, 32'h00000000, 1); waitDone(0, 5);
        applyStimulus(0, 2'b11, 32'h80000000, 32'hFFFFFFFF, 1); waitDone(0, 50);

        // Flush in the 10th CALC cycle: no done_o, and the old results remain.
        applyStimulus(0, 2'b00, 32'h12345678, 32'h9ABCDEF0, 0);
        repeat (10) @(negedge clk);
        flush32 = 1'b1;
        @(posedge clk);
        #1;
        flush32 = 1'b0;
        checkOutput("flush_busy", 64'(busy32), 64'd0);
        checkOutput("flush_hi", 64'(hi32), 64'h0);
        checkOutput("flush_lo", 64'(lo32), 64'h80000000);
        repeat (40) @(negedge clk);
        checkOutput("flush_hi_hold", 64'(hi32), 64'h0);
        checkOutput("flush_lo_hold", 64'(lo32), 64'h80000000);

        // Flush together with start while idle: the request is dropped.
        @(negedge clk);
        op32 = 2'b00; src1_32 = 32'h3; src2_32 = 32'h3; start32 = 1'b1; flush32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0; flush32 = 1'b0;
        checkOutput("idle_flush_busy", 64'(busy32), 64'd0);
        repeat (40) @(negedge clk);

        // Restart the flushed multiply.
        applyStimulus(0, 2'b00, 32'h12345678, 32'h9ABCDEF0, 1); waitDone(0, 50);

        // Reset mid-CALC clears the outputs at once, and no done_o follows.
        applyStimulus(0, 2'b00, 32'h12345678, 32'h9ABCDEF0, 0);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("midrst_busy", 64'(busy32), 64'd0);
        checkOutput("midrst_done", 64'(done32), 64'd0);
        checkOutput("midrst_hi", 64'(hi32), 64'd0);
        checkOutput("midrst_lo", 64'(lo32), 64'd0);
        checkOutput("midrst_dbz", 64'(dbz32), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("midrst_busy_after", 64'(busy32), 64'd0);

        // 8-bit instance.
        applyStimulus(1, 2'b00, 32'hFF, 32'hFF, 1); waitDone(1, 20);
        applyStimulus(1, 2'b01, 32'h80, 32'h80, 1); waitDone(1, 20);
        applyStimulus(1, 2'b11, 32'h80, 32'hFF, 1); waitDone(1, 20);
        applyStimulus(1, 2'b11, 32'hF3, 32'h00, 1); waitDone(1, 5);

        // Back-to-back divides. start_i toggles while busy and must be ignored.
        // The second request is accepted in the done_o cycle of the first.
        @(negedge clk);
        op32 = 2'b10; src1_32 = 32'd1000; src2_32 = 32'd7; start32 = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        e = modelOp(32, 2'b10, 32'd1000, 32'd7);
        e.due = c0 + 33;
        q32.push_back(e);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start32 = i[0];
            op32 = 2'($urandom);
            src1_32 = $urandom;
            src2_32 = $urandom;
        end
        @(negedge clk);
        op32 = 2'b10; src1_32 = 32'hDEADBEEF; src2_32 = 32'h00001234; start32 = 1'b1;
        e = modelOp(32, 2'b10, 32'hDEADBEEF, 32'h00001234);
        e.due = c0 + 34 + 33;
        q32.push_back(e);
        waitDone(0, 40);
        @(posedge clk);
        #1;
        start32 = 1'b0;
        checkOutput("b2b_busy", 64'(busy32), 64'd1);
        waitDone(0, 40);

        // Random operations on both widths. One divisor in each loop is zero.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 2'($urandom_range(0, 3)), $urandom,
                          (i == 3) ? 32'h0 : $urandom, 1);
            waitDone(0, 50);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 2'($urandom_range(0, 3)), $urandom,
                          (i == 2) ? 32'h0 : $urandom, 1);
            waitDone(1, 20);
        end

        repeat (5) @(negedge clk);
        checkOutput("q32_leftover", 64'(q32.size()), 64'd0);
        checkOutput("q8_leftover", 64'(q8.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
